// File: rtl/addsub_pkg.sv
// Shared constants for the chunked add/subtract unit: operation modes and FSM states.
package addsub_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_SLT  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit carry-chain slice; also exposes the carry into the MSB for signed overflow.
module addsub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] full;

    always_comb begin
        full   = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
        sum_o  = full[CHUNK-1:0];
        cout_o = full[CHUNK];
        // Sum bit is a^b^carry-in, so the MSB carry-in falls out of the XOR.
        cmsb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ full[CHUNK-1];
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub/SLT/pass unit, CHUNK bits per cycle with valid/ready on both sides.
// Define ADDSUB_SAT_EN to clamp overflowing add/sub results to the signed limits.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             S1,
    input  logic             S0,
    input  logic             C_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] x_q, y_q, sr_q, s_q;
    logic [KW-1:0]    k_q;
    logic             carry_q, v_q, c_q, n_q, z_q;

    logic [CHUNK-1:0] a_chunk, b_chunk, sum;
    logic             cout, cmsb, ovf, lt, last, accept, carry_init;
    logic [WIDTH-1:0] sraw, res_s;
    logic             res_v, res_c, res_n, res_z;

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (sum),
        .cout_o (cout),
        .cmsb_o (cmsb)
    );

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign last      = (k_q == KW'(NCH - 1));
    assign S         = s_q;
    assign V         = v_q;
    assign C         = c_q;
    assign N         = n_q;
    assign Z         = z_q;

    always_comb begin
        // Pass runs Y through the adder with a zero operand so latency stays uniform.
        a_chunk = (mode_q == MODE_PASS) ? '0 : x_q[CHUNK-1:0];
        b_chunk = ((mode_q == MODE_ADD) || (mode_q == MODE_PASS)) ? y_q[CHUNK-1:0]
                                                                    : ~y_q[CHUNK-1:0];
        sraw    = (sr_q >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
        ovf     = cmsb ^ cout;
        lt      = sum[CHUNK-1] ^ ovf;
    end

    always_comb begin
        unique case ({S1, S0})
            MODE_PASS: carry_init = 1'b0;
            MODE_ADD:  carry_init = C_in;
            default:   carry_init = 1'b1;
        endcase
    end

    // Result/flag selection; only meaningful on the final chunk.
    always_comb begin
        res_s = sraw;
        res_v = ovf;
        res_c = cout;
        res_n = sum[CHUNK-1];
        unique case (mode_q)
            MODE_PASS: begin
                res_v = 1'b0;
                res_c = 1'b0;
                res_n = 1'b0;
            end
            MODE_SUB: res_n = lt;
            MODE_SLT: begin
                res_s = {{(WIDTH-1){1'b0}}, lt};
                res_v = 1'b0;
                res_c = 1'b0;
                res_n = lt;
            end
            default: ;
        endcase
`ifdef ADDSUB_SAT_EN
        if (ovf && ((mode_q == MODE_ADD) || (mode_q == MODE_SUB))) begin
            res_s = {a_chunk[CHUNK-1], {(WIDTH-1){~a_chunk[CHUNK-1]}}};
        end
`endif
        res_z = (res_s == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_PASS;
            x_q     <= '0;
            y_q     <= '0;
            sr_q    <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else if (accept) begin
            state_q <= RUN;
            mode_q  <= {S1, S0};
            x_q     <= X;
            y_q     <= Y;
            k_q     <= '0;
            carry_q <= carry_init;
        end else begin
            unique case (state_q)
                RUN: begin
                    x_q     <= x_q >> CHUNK;
                    y_q     <= y_q >> CHUNK;
                    sr_q    <= sraw;
                    carry_q <= cout;
                    k_q     <= k_q + KW'(1);
                    if (last) begin
                        state_q <= DONE;
                        s_q     <= res_s;
                        v_q     <= res_v;
                        c_q     <= res_c;
                        n_q     <= res_n;
                        z_q     <= res_z;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed + random bench for addsub_seq (WIDTH=32, CHUNK=8) against an arithmetic model.
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, s1, s0, c_in, out_valid, out_ready;
    logic [31:0] x_in, y_in, s_out;
    logic        v_f, c_f, n_f, z_f;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_seq #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (x_in),
        .Y         (y_in),
        .S1        (s1),
        .S0        (s0),
        .C_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s_out),
        .V         (v_f),
        .C         (c_f),
        .N         (n_f),
        .Z         (z_f)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model from signed/unsigned integer arithmetic rather than chunked carries.
    function automatic void model(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, output logic [31:0] s,
                                  output logic [3:0] vcnz);
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint t;
        logic [32:0] full;
        logic v = 1'b0, c = 1'b0, n = 1'b0;
        case (m)
            2'b00: s = y;
            2'b01: begin
                full = {1'b0, x} + {1'b0, y} + {32'd0, ci};
                t    = sx + sy + longint'(ci);
                s    = full[31:0];
                c    = full[32];
                v    = (t != longint'($signed(s)));
                n    = s[31];
            end
            2'b10: begin
                full = {1'b0, x} + {1'b0, ~y} + 33'd1;
                t    = sx - sy;
                s    = full[31:0];
                c    = full[32];
                v    = (t != longint'($signed(s)));
                n    = (sx < sy);
            end
            default: begin
                t = 0;
                n = (sx < sy);
                s = {31'd0, n};
            end
        endcase
`ifdef ADDSUB_SAT_EN
        if (v) s = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        vcnz = {v, c, n, (s == 32'd0)};
    endfunction

    task automatic drive(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                         input logic ci);
        x_in     = x;
        y_in     = y;
        {s1, s0} = m;
        c_in     = ci;
        in_valid = 1'b1;
    endtask

    // After an accept edge (+#1), count cycles until out_valid, then check result.
    task automatic wait_check(input string tag, input logic [31:0] es, input logic [3:0] ef);
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd4);
        chk({tag, "_s"}, {32'd0, s_out}, {32'd0, es});
        chk({tag, "_flags"}, {60'd0, v_f, c_f, n_f, z_f}, {60'd0, ef});
    endtask

    task automatic op(input string tag, input logic [1:0] m, input logic [31:0] x,
                      input logic [31:0] y, input logic ci);
        logic [31:0] es;
        logic [3:0]  ef;
        model(m, x, y, ci, es, ef);
        @(negedge clk);
        chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        drive(m, x, y, ci);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = $urandom;
        y_in     = $urandom;
        c_in     = 1'($urandom);
        wait_check(tag, es, ef);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [31:0] es, hs;
        logic [3:0]  ef, hf;
        int          seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x_in = '0; y_in = '0; s1 = 1'b0; s0 = 1'b0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_s", {32'd0, s_out}, 64'd0);
        chk("rst_flags", {60'd0, v_f, c_f, n_f, z_f}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", {63'd0, in_ready}, 64'd1);

        op("add_ff_1", 2'b01, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        op("add_wrap", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        op("add_wrap_ci", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        op("sub_ovf", 2'b10, 32'h8000_0000, 32'h0000_0001, 1'b0);
        op("slt_neg", 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        op("slt_pos", 2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0);
        op("pass_zero", 2'b00, 32'h1234_5678, 32'h0000_0000, 1'b1);
        op("add_povf", 2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        op("sub_eq", 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

        // Test-plan literals, independent of the model.
`ifdef ADDSUB_SAT_EN
        model(2'b10, 32'h8000_0000, 32'h1, 1'b0, es, ef);
        chk("plan_sub_sat", {32'd0, es}, 64'h8000_0000);
`else
        model(2'b10, 32'h8000_0000, 32'h1, 1'b0, es, ef);
        chk("plan_sub_wrap", {32'd0, es}, 64'h7FFF_FFFF);
`endif
        chk("plan_sub_flags", {60'd0, ef}, 64'b1110);

        for (int i = 0; i < 40; i++) begin
            op("rand", 2'($urandom), $urandom, (i % 5 == 0) ? 32'd0 : $urandom, 1'($urandom));
        end

        // Backpressure then back-to-back accept on the DONE->RUN path.
        @(negedge clk);
        model(2'b01, 32'h1357_9BDF, 32'h8642_0ACE, 1'b1, hs, hf);
        drive(2'b01, 32'h1357_9BDF, 32'h8642_0ACE, 1'b1);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_check("bp_first", hs, hf);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_hold_s", {32'd0, s_out}, {32'd0, hs});
            chk("bp_hold_flags", {60'd0, v_f, c_f, n_f, z_f}, {60'd0, hf});
            chk("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        model(2'b10, 32'h0000_0003, 32'h0000_0007, 1'b0, es, ef);
        drive(2'b10, 32'h0000_0003, 32'h0000_0007, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("b2b_rdy", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_valid_drop", {63'd0, out_valid}, 64'd0);
        wait_check("b2b_second", es, ef);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during RUN cycle 2 aborts the operation.
        @(negedge clk);
        drive(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_s", {32'd0, s_out}, 64'd0);
        chk("abort_flags", {60'd0, v_f, c_f, n_f, z_f}, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rdy", {63'd0, in_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-cycle, parametrised add/subtract unit: the sequential successor to the single-cycle combinational adder in the RV32I datapath. Operands are processed CHUNK bits per cycle through one CHUNK-bit carry-chain adder, trading latency for area. A valid/ready handshake sits on both the operand and the result sides. It adds a set-less-than mode, correct signed flags for subtraction, and optional saturation.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; NCH = WIDTH/CHUNK.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  unit can accept operands.
- X, Y  in  WIDTH  operands.
- S1, S0  in  1 each  mode {S1,S0}: 00 pass Y, 01 add, 10 sub, 11 SLT.
- C_in  in  1  carry-in; used by add only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  result.
- V, C, N, Z  out  1 each  overflow, carry, negative/less-than, zero flags.

## Operation
- FSM states:
  - IDLE: in_ready=1. Transfer on in_valid&&in_ready latches X, Y, mode and C_in, clears chunk index k to 0, and moves to RUN.
  - RUN: each cycle adds chunk k. Add: X[k] + Y[k]. Sub/SLT: X[k] + ~Y[k]. The carry register carries between chunks. Initial carry is C_in for add, 1 for sub/SLT, and 0 for pass. Pass Y still iterates so latency is uniform. After chunk NCH-1, results and flags are registered and the FSM moves to DONE.
  - DONE: out_valid=1, and S and the flags hold stable. On out_ready the FSM returns to IDLE. If in_valid is also high in that cycle, the new operands are accepted and the FSM moves straight to RUN.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Result and flags by mode:
  - Pass: S=Y, C=0, V=0, N=0, Z=(Y==0).
  - Add: S = X+Y+C_in mod 2^WIDTH. C = carry out. V = (X[msb]==Y[msb]) && (S[msb]!=X[msb]). N = S[msb]. Z = (S==0).
  - Sub: S = X−Y mod 2^WIDTH. C = carry out of X+~Y+1 (1 means no borrow). V = (X[msb]!=Y[msb]) && (Sraw[msb]!=X[msb]). N = signed(X)<signed(Y) = Sraw[msb]^V. Z = (S==0).
  - SLT: S = {0…, signed(X)<signed(Y)}. N = that same bit. C=0, V=0, Z=(S==0).
- Flags are computed from the un-saturated result Sraw, except Z, which uses the final S.
- Operand inputs are ignored outside an accepted transfer; internal copies are stable through RUN.

## Timing
- Reset (rst_n low at a clock edge):
  - state=IDLE, k=0, carry=0, S=0, and V=C=N=Z=0; out_valid=0.
  - in_ready=1 from the first cycle after rst_n is deasserted.
- Reset in the middle of RUN or DONE aborts the operation; no result is emitted.
- Latency: out_valid rises NCH cycles after the acceptance edge (4 cycles for 32/8).
- Peak throughput: one result per NCH cycles, with back-to-back accept on the DONE→RUN path.
- Backpressure: out_valid, S and the flags hold unchanged while out_ready=0; no limit on the hold time.
- CHUNK=WIDTH is legal: NCH=1, single-cycle compute plus the registered output.

## Configuration
- ADDSUB_SAT_EN defined:
  - In add and sub, when V=1, S clamps to 0x7FF…F if the true result is positive (X[msb]=0) or to 0x800…0 if it is negative.
  - V, C and N still report the raw overflow/carry.
  - No effect in pass or SLT.
- ADDSUB_SAT_EN undefined: results wrap modulo 2^WIDTH, and the saturation logic is absent.

## Structure
- Package addsub_pkg holds:
  - the mode constants MODE_PASS=2'b00, MODE_ADD=2'b01, MODE_SUB=2'b10, MODE_SLT=2'b11;
  - the FSM state encoding IDLE/RUN/DONE.
- One sub-module, addsub_chunk: a CHUNK-bit ripple-carry adder (a, b, cin → sum, cout, and the MSB carry-in used for V).
- The top level holds the FSM, operand/result shift registers, carry register, flag logic and the optional saturation logic.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.

1. Add, X=0x000000FF, Y=0x00000001, C_in=0 → S=0x00000100, C=0, V=0, Z=0, N=0; out_valid exactly 4 cycles after accept.
2. Add, X=0xFFFFFFFF, Y=0x00000001, C_in=0 → S=0, C=1, Z=1, V=0. Same operands with C_in=1 → S=0x00000001, C=1, Z=0.
3. Sub, X=0x80000000, Y=0x00000001:
   - without ADDSUB_SAT_EN → S=0x7FFFFFFF, V=1, C=1, N=1;
   - with ADDSUB_SAT_EN → S=0x80000000, same flags.
4. SLT, X=0xFFFFFFFE, Y=0x00000003 → S=1, N=1, Z=0. SLT, X=5, Y=3 → S=0, N=0, Z=1. Pass, Y=0 → S=0, Z=1.
5. Backpressure and back-to-back:
   - hold out_ready=0 for 3 cycles → S and flags unchanged, in_ready=0;
   - assert out_ready with in_valid high → the next operation is accepted in the same cycle and its result appears 4 cycles later.
6. Reset abort: pull rst_n low during RUN cycle 2 → out_valid=0, S=0, all flags 0; in_ready=1 after release, and the aborted result never appears.
